// File: rtl/blk_mm_pkg.sv
// Shared types and helpers for the 2x2 block matrix multiply.
// Used by the scheduler RTL and by datapath models.
package blk_mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    ISSUE1,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam int TILE_W = 2;
  localparam int CNT_W = 3;
  localparam logic [TILE_W-1:0] TILE_LAST = 2'd3;

  // A-side block select {i,k}
  function automatic logic [1:0] sel_ik(
    input logic [TILE_W-1:0] tile,
    input logic k
  );
    return {tile[1], k};
  endfunction

  // B-side block select {k,j}
  function automatic logic [1:0] sel_kj(
    input logic [TILE_W-1:0] tile,
    input logic k
  );
    return {k, tile[0]};
  endfunction

endpackage

// File: rtl/blk_drain_timer.sv
// Loadable down-counter timing the MAC pipeline drain.
// zero is high once the count has run out.
module blk_drain_timer
  import blk_mm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // load wins; otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/blk_mux_sched.sv
// Sequencer for the block-input muxes and MAC of the 2x2 multiply.
// Optional BLK_SCHED_PERF_EN adds the stall_cnt write-back stall counter.
module blk_mux_sched
  import blk_mm_pkg::*;
#(
  parameter int PIPE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              mux_rst,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [TILE_W-1:0] wr_idx
`ifdef BLK_SCHED_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    (PIPE_LAT == 0) ? '0 : CNT_W'(PIPE_LAT - 1);

  state_t            state;
  state_t            state_nx;
  logic [TILE_W-1:0] tile;
  logic              tmr_load;
  logic              tmr_zero;
  logic              k;

  // timer is loaded on the cycle before DRAIN
  assign tmr_load = (state == ISSUE1);

  blk_drain_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (DRAIN_LOAD),
    .zero     (tmr_zero)
  );

  // state register and tile index
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tile  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        tile <= '0;
      end else if (state == WRITE && wr_ready &&
                   tile != TILE_LAST) begin
        tile <= tile + 1'b1;
      end
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = ISSUE0;
      ISSUE0: state_nx = ISSUE1;
      ISSUE1: state_nx = (PIPE_LAT == 0) ? WRITE : DRAIN;
      DRAIN:  if (tmr_zero) state_nx = WRITE;
      WRITE: begin
        if (wr_ready) begin
          state_nx = (tile == TILE_LAST) ? DONE : ISSUE0;
        end
      end
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore output decode from state and tile
  always_comb begin
    busy     = 1'b1;
    done     = 1'b0;
    mux_rst  = 1'b1;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    wr_valid = 1'b0;
    wr_idx   = '0;
    k        = 1'b0;
    sel_a    = '0;
    sel_b    = '0;
    unique case (state)
      IDLE: busy = 1'b0;
      ISSUE0: begin
        mux_rst = 1'b0;
        acc_clr = 1'b1;
        acc_en  = 1'b1;
        sel_a   = sel_ik(tile, k);
        sel_b   = sel_kj(tile, k);
      end
      ISSUE1: begin
        k       = 1'b1;
        mux_rst = 1'b0;
        acc_en  = 1'b1;
        sel_a   = sel_ik(tile, k);
        sel_b   = sel_kj(tile, k);
      end
      DRAIN: ;
      WRITE: begin
        wr_valid = 1'b1;
        wr_idx   = tile;
      end
      DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

`ifdef BLK_SCHED_PERF_EN
  // saturating count of stalled write-back cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == WRITE && !wr_ready &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_blk_mux_sched.sv
// Scoreboard bench for blk_mux_sched with a mux/MAC datapath model.
// Extra instances at PIPE_LAT 0 and 7 check per-tile length.
module tb_blk_mux_sched;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       clr;
  } iss_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] c;
  } wr_t;

  localparam logic [1:0] EA [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
  localparam logic [1:0] EB [8] = '{0, 2, 1, 3, 0, 2, 1, 3};
  localparam logic [31:0] GOLD [4] =
    '{32'd720896, 32'd393216, 32'd196608, 32'd131072};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       wr_ready = 1'b1;
  logic       busy, done, mux_rst, acc_clr, acc_en, wr_valid;
  logic [1:0] sel_a, sel_b, wr_idx;

  logic       busy0, done0, mrst0, aclr0, aen0, wv0;
  logic [1:0] sa0, sb0, wi0;
  logic       busy7, done7, mrst7, aclr7, aen7, wv7;
  logic [1:0] sa7, sb7, wi7;
`ifdef BLK_SCHED_PERF_EN
  logic [15:0] stall_cnt, stall0, stall7;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  iss_t iq[$];
  wr_t  wq[$];
  iss_t ie;
  wr_t  we;

  logic [15:0] mux_a, mux_b;
  logic [31:0] acc;

  always #5 clk = ~clk;

  blk_mux_sched #(.PIPE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .sel_a(sel_a), .sel_b(sel_b),
    .mux_rst(mux_rst), .acc_clr(acc_clr),
    .acc_en(acc_en), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_idx(wr_idx)
`ifdef BLK_SCHED_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  blk_mux_sched #(.PIPE_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy0), .done(done0),
    .sel_a(sa0), .sel_b(sb0),
    .mux_rst(mrst0), .acc_clr(aclr0),
    .acc_en(aen0), .wr_valid(wv0),
    .wr_ready(1'b1), .wr_idx(wi0)
`ifdef BLK_SCHED_PERF_EN
    , .stall_cnt(stall0)
`endif
  );

  blk_mux_sched #(.PIPE_LAT(7)) dut7 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy7), .done(done7),
    .sel_a(sa7), .sel_b(sb7),
    .mux_rst(mrst7), .acc_clr(aclr7),
    .acc_en(aen7), .wr_valid(wv7),
    .wr_ready(1'b1), .wr_idx(wi7)
`ifdef BLK_SCHED_PERF_EN
    , .stall_cnt(stall7)
`endif
  );

  function automatic logic [15:0] mux_in(input logic [1:0] s);
    case (s)
      2'd0: return 16'h0300;
      2'd1: return 16'h0200;
      2'd2: return 16'h0100;
      default: return 16'h0000;
    endcase
  endfunction

  assign mux_a = mux_rst ? 16'h0 : mux_in(sel_a);
  assign mux_b = mux_rst ? 16'h0 : mux_in(sel_b);

  always @(posedge clk) begin
    if (rst) acc <= '0;
    else if (acc_en)
      acc <= (acc_clr ? 32'd0 : acc) +
             32'(mux_a) * 32'(mux_b);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (acc_en) begin
        if (iq.size() == 0) begin
          check("issue_unexpected", 32'd1, 32'd0);
        end else begin
          ie = iq.pop_front();
          check("sel_a", 32'(sel_a), 32'(ie.a));
          check("sel_b", 32'(sel_b), 32'(ie.b));
          check("acc_clr", 32'(acc_clr), 32'(ie.clr));
        end
      end else begin
        check("sel_idle",
              32'({sel_a, sel_b, acc_clr}), 32'd0);
      end
      check("mux_rst", 32'(mux_rst), 32'(!acc_en));
      if (wr_valid && wr_ready) begin
        if (wq.size() == 0) begin
          check("write_unexpected", 32'd1, 32'd0);
        end else begin
          we = wq.pop_front();
          check("wr_idx", 32'(wr_idx), 32'(we.idx));
          check("c_tile", acc, we.c);
        end
      end
    end
  end

  task automatic push_run();
    for (int t = 0; t < 4; t++) begin
      iq.push_back('{EA[2*t], EB[2*t], 1'b1});
      iq.push_back('{EA[2*t+1], EB[2*t+1], 1'b0});
      wq.push_back('{t[1:0], GOLD[t]});
    end
  endtask

  task automatic do_run(input int stall_len,
                        input int pulse_at,
                        input int exp_done,
                        input bit chk_lat);
    int n, stl, dn, nd, d0, d7;
    bit g, g0, g7, pstl;
    push_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; stl = stall_len; nd = 0;
    dn = 0; d0 = 0; d7 = 0;
    g = 0; g0 = 0; g7 = 0; pstl = 0;
    while (n <= 80 && !(g && g0 && g7)) begin
      start = (n == pulse_at);
      if (pstl) begin
        check("stall_valid", 32'(wr_valid), 32'd1);
        check("stall_idx", 32'(wr_idx), 32'd1);
      end
      wr_ready = 1'b1;
      pstl = 0;
      if (wr_valid && wr_idx == 2'd1 && stl > 0) begin
        wr_ready = 1'b0;
        stl--;
        pstl = 1;
      end
      if (done) begin
        if (!g) dn = n;
        g = 1;
        nd++;
      end
      if (done0 && !g0) begin g0 = 1; d0 = n; end
      if (done7 && !g7) begin g7 = 1; d7 = n; end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    wr_ready = 1'b1;
    repeat (4) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    check("done_cycle", dn, exp_done);
    check("done_count", nd, 1);
    if (chk_lat) begin
      check("lat0_done", d0, 13);
      check("lat7_done", d7, 41);
    end
    check("issue_left", iq.size(), 0);
    check("write_left", wq.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sel"}, 32'({sel_a, sel_b}), 32'd0);
    check({tag, "_mux_rst"}, 32'(mux_rst), 32'd1);
    check({tag, "_acc"}, 32'({acc_clr, acc_en}), 32'd0);
    check({tag, "_wr"}, 32'({wr_valid, wr_idx}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
`ifdef BLK_SCHED_PERF_EN
    check("stall_reset", 32'(stall_cnt), 32'd0);
`endif
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_run(0, 0, 17, 1'b1);
    do_run(5, 0, 22, 1'b0);
`ifdef BLK_SCHED_PERF_EN
    check("stall_cnt", 32'(stall_cnt), 32'd5);
`endif
    do_run(0, 9, 17, 1'b0);
`ifdef BLK_SCHED_PERF_EN
    check("stall_clear", 32'(stall_cnt), 32'd0);
`endif

    push_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_sel_a", 32'({acc_en, sel_a}), 32'h7);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("mid_rst");
    iq.delete();
    wq.delete();
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_done", 32'({busy, done}), 32'd0);
    end
    do_run(0, 0, 17, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
